// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Single-clock synchronous FIFO with register-array storage, sitting between
// the message byte stream and the field parsers. Provides a true occupancy
// count (0..DEPTH), almost-full/almost-empty flags, sticky overflow/underflow
// errors and a choice of registered or first-word-fall-through read.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active low
//   wr_en_i        write request
//   data_i         write data
//   rd_en_i        read request (FWFT: pop of the head word)
//   clr_err_i      clears overflow_o/underflow_o (wins over a same-cycle set)
//   data_o         read data
//   valid_o        data_o holds a valid word
//   empty_o        level_o == 0
//   full_o         level_o == DEPTH
//   almost_full_o  level_o >= AF_LEVEL
//   almost_empty_o level_o <= AE_LEVEL
//   level_o        occupancy, 0..DEPTH
//   overflow_o     sticky: a write was rejected
//   underflow_o    sticky: a read was rejected
// -----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_en_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    if ((AF_LEVEL > DEPTH) || (AE_LEVEL >= DEPTH)) begin : g_param_err
        $error("fifo_sync_param: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc, wr_acc;

    // Flags come from the registered level, so they move together with level_o.
    assign empty_o        = (level_q == '0);
    assign full_o         = (level_q == DEPTH_L);
    assign almost_full_o  = (level_q >= AF_L);
    assign almost_empty_o = (level_q <= AE_L);
    assign level_o        = level_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

    // A read frees a slot in the same edge, so a full FIFO still takes a write
    // alongside a read. An empty FIFO never bypasses write data to the read.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        level_d = level_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
        // Clear beats a same-cycle set.
        if (clr_err_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q || (wr_en_i && !wr_acc);
            udf_d = udf_q || (rd_en_i && !rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) mem_q[wr_ptr_q] <= data_i;
    end

    if (FWFT) begin : g_fwft
        // Head word is presented combinationally; forced to zero while empty
        // so that stale storage never leaks out (and reset shows data_o = 0).
        assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        assign valid_o = !empty_o;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  vld_q, vld_d;

        always_comb begin
            dout_d = dout_q;
            vld_d  = rd_acc;
            if (rd_acc) dout_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                dout_q <= dout_d;
                vld_q  <= vld_d;
            end
        end

        assign data_o  = dout_q;
        assign valid_o = vld_q;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
// Bench for fifo_sync_param with DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// One instance in registered-read mode, one in FWFT mode.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int AW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance
    logic          rst, wr, rd, clr;
    logic [DW-1:0] din, dout;
    logic          vld, emp, ful, af, ae, ovf, udf;
    logic [AW:0]   lvl;

    // FWFT instance
    logic          rst_f, wr_f, rd_f, clr_f;
    logic [DW-1:0] din_f, dout_f;
    logic          vld_f, emp_f, ful_f, af_f, ae_f, ovf_f, udf_f;
    logic [AW:0]   lvl_f;

    fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr), .data_i(din), .rd_en_i(rd), .clr_err_i(clr),
        .data_o(dout), .valid_o(vld), .empty_o(emp), .full_o(ful), .almost_full_o(af),
        .almost_empty_o(ae), .level_o(lvl), .overflow_o(ovf), .underflow_o(udf)
    );

    fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) dut_f (
        .clk(clk), .rst(rst_f), .wr_en_i(wr_f), .data_i(din_f), .rd_en_i(rd_f), .clr_err_i(clr_f),
        .data_o(dout_f), .valid_o(vld_f), .empty_o(emp_f), .full_o(ful_f), .almost_full_o(af_f),
        .almost_empty_o(ae_f), .level_o(lvl_f), .overflow_o(ovf_f), .underflow_o(udf_f)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // flags = {full, empty, af, ae, ovf, udf, vld}
    task automatic check_std(input string tag, input logic [AW:0] l, input logic [6:0] f,
                             input logic [DW-1:0] d);
        chk({tag, " level"},    32'(lvl), 32'(l));
        chk({tag, " full"},     32'(ful), 32'(f[6]));
        chk({tag, " empty"},    32'(emp), 32'(f[5]));
        chk({tag, " afull"},    32'(af),  32'(f[4]));
        chk({tag, " aempty"},   32'(ae),  32'(f[3]));
        chk({tag, " overflow"}, 32'(ovf), 32'(f[2]));
        chk({tag, " underflow"},32'(udf), 32'(f[1]));
        chk({tag, " valid"},    32'(vld), 32'(f[0]));
        chk({tag, " data"},     32'(dout),32'(d));
    endtask

    task automatic check_fwft(input string tag, input logic [AW:0] l, input logic [6:0] f,
                              input logic [DW-1:0] d, input bit chk_data);
        chk({tag, " level"},    32'(lvl_f), 32'(l));
        chk({tag, " full"},     32'(ful_f), 32'(f[6]));
        chk({tag, " empty"},    32'(emp_f), 32'(f[5]));
        chk({tag, " afull"},    32'(af_f),  32'(f[4]));
        chk({tag, " aempty"},   32'(ae_f),  32'(f[3]));
        chk({tag, " overflow"}, 32'(ovf_f), 32'(f[2]));
        chk({tag, " underflow"},32'(udf_f), 32'(f[1]));
        chk({tag, " valid"},    32'(vld_f), 32'(f[0]));
        if (chk_data) chk({tag, " data"}, 32'(dout_f), 32'(d));
    endtask

    task automatic step(input logic r, input logic w, input logic rr, input logic c,
                        input logic [DW-1:0] d);
        @(negedge clk);
        rst = r; wr = w; rd = rr; clr = c; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_f(input logic r, input logic w, input logic rr, input logic c,
                          input logic [DW-1:0] d);
        @(negedge clk);
        rst_f = r; wr_f = w; rd_f = rr; clr_f = c; din_f = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference (registered-read mode) ----------
    logic [DW-1:0] m_q[$];
    bit            m_ovf, m_udf, m_vld;
    logic [DW-1:0] m_dout;

    task automatic model_step(input bit r, input bit w, input bit rr, input bit c,
                              input logic [DW-1:0] d);
        bit ra, wa;
        if (!r) begin
            m_q.delete();
            m_ovf = 0; m_udf = 0; m_vld = 0; m_dout = '0;
        end else begin
            ra = rr && (m_q.size() > 0);
            wa = w && ((m_q.size() < 4) || ra);
            m_vld = ra;
            if (ra) m_dout = m_q.pop_front();
            if (wa) m_q.push_back(d);
            if (c) begin
                m_ovf = 0; m_udf = 0;
            end else begin
                if (w && !wa) m_ovf = 1;
                if (rr && !ra) m_udf = 1;
            end
        end
    endtask

    function automatic logic [6:0] model_flags();
        int n = m_q.size();
        return {n == 4, n == 0, n >= 3, n <= 1, m_ovf, m_udf, m_vld};
    endfunction

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic [2:0]    op;      // {wr, rd, clr}
        logic [DW-1:0] din;
        logic [AW:0]   lvl;
        logic [6:0]    flags;   // {full, empty, af, ae, ovf, udf, vld}
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{3'b100, 8'h11, 3'd1, 7'b0001000, 8'h00};
        tbl[1]  = '{3'b100, 8'h22, 3'd2, 7'b0000000, 8'h00};
        tbl[2]  = '{3'b100, 8'h33, 3'd3, 7'b0010000, 8'h00};
        tbl[3]  = '{3'b100, 8'h44, 3'd4, 7'b1010000, 8'h00};
        tbl[4]  = '{3'b100, 8'h55, 3'd4, 7'b1010100, 8'h00};  // overflow
        tbl[5]  = '{3'b001, 8'h00, 3'd4, 7'b1010000, 8'h00};  // clear
        tbl[6]  = '{3'b110, 8'h55, 3'd4, 7'b1010001, 8'h11};  // full rd+wr
        tbl[7]  = '{3'b010, 8'h00, 3'd3, 7'b0010001, 8'h22};
        tbl[8]  = '{3'b010, 8'h00, 3'd2, 7'b0000001, 8'h33};
        tbl[9]  = '{3'b010, 8'h00, 3'd1, 7'b0001001, 8'h44};
        tbl[10] = '{3'b010, 8'h00, 3'd0, 7'b0101001, 8'h55};
        tbl[11] = '{3'b000, 8'h00, 3'd0, 7'b0101000, 8'h55};  // data held
        tbl[12] = '{3'b010, 8'h00, 3'd0, 7'b0101010, 8'h55};  // underflow
        tbl[13] = '{3'b001, 8'h00, 3'd0, 7'b0101000, 8'h55};
        tbl[14] = '{3'b110, 8'h77, 3'd1, 7'b0001010, 8'h55};  // empty rd+wr
        tbl[15] = '{3'b010, 8'h00, 3'd0, 7'b0101011, 8'h77};
        tbl[16] = '{3'b011, 8'h00, 3'd0, 7'b0101000, 8'h77};  // clr beats set

        rst = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
        rst_f = 1'b0; wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0; din_f = '0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_std("reset", 3'd0, 7'b0101000, 8'h00);

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].op[2], tbl[i].op[1], tbl[i].op[0], tbl[i].din);
            check_std($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].flags, tbl[i].dout);
        end

        // Pointer wrap: alternate write/read, value must come straight back.
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] v;
            v = 8'hA0 + 8'(i);
            step(1'b1, 1'b1, 1'b0, 1'b0, v);
            check_std($sformatf("wrap_wr%0d", i), 3'd1, 7'b0001000, (i == 0) ? 8'h77 : v - 8'h01);
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            check_std($sformatf("wrap_rd%0d", i), 3'd0, 7'b0101001, v);
        end

        // Randomised traffic against the queue model, with occasional resets.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            bit r, w, rr, c;
            logic [DW-1:0] d;
            int wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            r  = ($urandom_range(0, 59) != 0);
            w  = ($urandom_range(0, 99) < wp);
            rr = ($urandom_range(0, 99) < (100 - wp));
            c  = ($urandom_range(0, 15) == 0);
            d  = 8'($urandom);
            step(r, w, rr, c, d);
            model_step(r, w, rr, c, d);
            check_std($sformatf("rnd%0d", i), 3'(m_q.size()), model_flags(), m_dout);
        end

        // FWFT instance.
        step_f(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_fwft("f_reset", 3'd0, 7'b0101000, 8'h00, 1'b1);
        step_f(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        check_fwft("f_wr3c", 3'd1, 7'b0001001, 8'h3C, 1'b1);
        step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_fwft("f_hold", 3'd1, 7'b0001001, 8'h3C, 1'b1);
        step_f(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_fwft("f_pop", 3'd0, 7'b0101000, 8'h00, 1'b0);
        step_f(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        check_fwft("f_wr10", 3'd1, 7'b0001001, 8'h10, 1'b1);
        step_f(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        check_fwft("f_wr20", 3'd2, 7'b0000001, 8'h10, 1'b1);
        step_f(1'b1, 1'b1, 1'b1, 1'b0, 8'h30);
        check_fwft("f_rdwr", 3'd2, 7'b0000001, 8'h20, 1'b1);
        step_f(1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
        check_fwft("f_midrst", 3'd0, 7'b0101000, 8'h00, 1'b1);
        step_f(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        check_fwft("f_postrst", 3'd1, 7'b0001001, 8'h99, 1'b1);
        step_f(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_fwft("f_drain", 3'd0, 7'b0101000, 8'h00, 1'b0);
        step_f(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_fwft("f_udf", 3'd0, 7'b0101010, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
